// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes and sequencer state encoding
package alu_pkg;

   localparam int NB_OP_DEF = 6;

   localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'b100000;
   localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'b100010;
   localparam logic [NB_OP_DEF-1:0] OP_AND = 6'b100100;
   localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'b100101;
   localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'b100110;
   localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'b100111;
   localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'b000011;
   localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'b000010;

   // One-hot so the busy decode is a simple OR of three bits.
   typedef enum logic [5:0] {
      ST_WAIT_A  = 6'b000001,
      ST_WAIT_B  = 6'b000010,
      ST_WAIT_OP = 6'b000100,
      ST_COMPUTE = 6'b001000,
      ST_SEND    = 6'b010000,
      ST_WAIT_TX = 6'b100000
   } seq_state_t;

   function automatic logic is_supported_op(input logic [NB_OP_DEF-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_XOR, OP_NOR, OP_SRA, OP_SRL: is_supported_op = 1'b1;
         default:                        is_supported_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// rtl/seq_timeout_counter.sv - inter-byte timeout counter for the serial ALU sequencer
module seq_timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count;

   // Saturates at LAST so a stalled enable cannot wrap and miss the expiry.
   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         count <= '0;
      end else if (i_enable && (count != LAST)) begin
         count <= count + CNT_W'(1);
      end
   end

   assign o_expired = i_enable && (count == LAST);

endmodule

// File: rtl/alu_uart_sequencer.sv
// rtl/alu_uart_sequencer.sv - UART byte stream to ALU operand/opcode sequencer
// Optional inter-byte timeout enabled by defining ALU_UART_SEQ_TIMEOUT_EN.
module alu_uart_sequencer
   import alu_pkg::*;
#(
   parameter int          NB_DATA        = 8,
   parameter int          NB_OP          = NB_OP_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_done,
   input  logic               i_tx_done,
   input  logic [NB_DATA-1:0] i_alu_result,
   output logic [NB_DATA-1:0] o_alu_a,
   output logic [NB_DATA-1:0] o_alu_b,
   output logic [NB_OP-1:0]   o_alu_op,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_start,
   output logic               o_busy,
   output logic               o_op_err,
   output logic               o_drop
);

   seq_state_t state;
   seq_state_t state_next;

   logic op_ok;
   logic timeout_hit;
   logic in_collect;

   assign op_ok      = is_supported_op(i_rx_data[NB_OP-1:0]);
   assign in_collect = (state == ST_WAIT_B) || (state == ST_WAIT_OP);

`ifdef ALU_UART_SEQ_TIMEOUT_EN
   logic expired;

   // Clearing outside the collect states makes every entry start from zero.
   seq_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_clear  (i_rx_done || !in_collect),
      .i_enable (in_collect),
      .o_expired(expired)
   );

   assign timeout_hit = expired && !i_rx_done;
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = ^TIMEOUT_CYCLES ^ in_collect;
   assign timeout_hit        = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= ST_WAIT_A;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_WAIT_A: begin
            if (i_rx_done) state_next = ST_WAIT_B;
         end
         ST_WAIT_B: begin
            if (i_rx_done)        state_next = ST_WAIT_OP;
            else if (timeout_hit) state_next = ST_WAIT_A;
         end
         ST_WAIT_OP: begin
            if (i_rx_done)        state_next = op_ok ? ST_COMPUTE : ST_WAIT_A;
            else if (timeout_hit) state_next = ST_WAIT_A;
         end
         ST_COMPUTE: state_next = ST_SEND;
         ST_SEND:    state_next = ST_WAIT_TX;
         ST_WAIT_TX: begin
            if (i_tx_done) state_next = ST_WAIT_A;
         end
         default:    state_next = ST_WAIT_A;
      endcase
   end

   always_comb begin
      o_busy     = (state == ST_COMPUTE) || (state == ST_SEND) || (state == ST_WAIT_TX);
      o_tx_start = (state == ST_SEND);
   end

   // Operand, opcode and result registers plus the registered error/drop pulses.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_alu_a   <= '0;
         o_alu_b   <= '0;
         o_alu_op  <= '0;
         o_tx_data <= '0;
         o_op_err  <= 1'b0;
         o_drop    <= 1'b0;
      end else begin
         o_op_err <= 1'b0;
         o_drop   <= 1'b0;
         case (state)
            ST_WAIT_A: begin
               if (i_rx_done) o_alu_a <= i_rx_data;
            end
            ST_WAIT_B: begin
               if (i_rx_done)        o_alu_b  <= i_rx_data;
               else if (timeout_hit) o_op_err <= 1'b1;
            end
            ST_WAIT_OP: begin
               if (i_rx_done) begin
                  o_alu_op <= i_rx_data[NB_OP-1:0];
                  o_op_err <= !op_ok;
               end else if (timeout_hit) begin
                  o_op_err <= 1'b1;
               end
            end
            ST_COMPUTE: begin
               o_tx_data <= i_alu_result;
               o_drop    <= i_rx_done;
            end
            ST_SEND,
            ST_WAIT_TX: o_drop <= i_rx_done;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// tb/tb_alu_uart_sequencer.sv - randomized self-checking bench for alu_uart_sequencer
module tb_alu_uart_sequencer;

`ifdef ALU_UART_SEQ_TIMEOUT_EN
   localparam int unsigned TO_CYCLES = 16;
`else
   localparam int unsigned TO_CYCLES = 50_000_000;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] rx_data = '0;
   logic       rx_done = 1'b0;
   logic       tx_done = 1'b0;
   logic [7:0] alu_result;
   logic [7:0] alu_a, alu_b, tx_data;
   logic [5:0] alu_op;
   logic       tx_start, busy, op_err, drop;

   int n_checks = 0;
   int n_pass   = 0;
   int n_starts = 0;
   int n_errs   = 0;

   logic [7:0] a_exp = '0, b_exp = '0, tx_exp = '0;
   logic [5:0] op_exp = '0;

   logic [5:0] valid_ops [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                 6'b100110, 6'b100111, 6'b000011, 6'b000010};

   always #5 clk = ~clk;

   alu_uart_sequencer #(
      .NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(TO_CYCLES)
   ) dut (
      .i_clk(clk), .i_reset(reset), .i_rx_data(rx_data), .i_rx_done(rx_done),
      .i_tx_done(tx_done), .i_alu_result(alu_result),
      .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op), .o_tx_data(tx_data),
      .o_tx_start(tx_start), .o_busy(busy), .o_op_err(op_err), .o_drop(drop)
   );

   function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
      case (op)
         6'b100000: return a + b;
         6'b100010: return a - b;
         6'b100100: return a & b;
         6'b100101: return a | b;
         6'b100110: return a ^ b;
         6'b100111: return ~(a | b);
         6'b000011: return $signed(a) >>> b;
         6'b000010: return a >> b;
         default:   return 8'h00;
      endcase
   endfunction

   function automatic bit op_valid(input logic [5:0] op);
      foreach (valid_ops[i]) if (valid_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   assign alu_result = alu_ref(alu_a, alu_b, alu_op);

   always @(negedge clk) begin
      if (tx_start) n_starts++;
      if (op_err)   n_errs++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_data = b;
      rx_done = 1'b1;
      @(posedge clk); #1;
      rx_done = 1'b0;
      rx_data = 8'($urandom);
   endtask

   // Entered one cycle after the opcode edge; drop_mode 0 none, 1 with tx_done, 2 before tx_done.
   task automatic finish_txn(input int tx_wait, input int drop_mode);
      int starts0 = n_starts;
      @(negedge clk);
      check("alu_a", alu_a, a_exp);
      check("alu_b", alu_b, b_exp);
      check("alu_op", alu_op, op_exp);
      if (op_valid(op_exp)) begin
         tx_exp = alu_ref(a_exp, b_exp, op_exp);
         check("busy_compute", busy, 1);
         check("tx_start_early", tx_start, 0);
         @(negedge clk);
         check("tx_start", tx_start, 1);
         check("tx_data", tx_data, tx_exp);
         @(posedge clk); #1;
         for (int i = 0; i < tx_wait; i++) begin
            @(posedge clk); #1;
         end
         if (drop_mode == 2) begin
            rx_data = 8'h55; rx_done = 1'b1;
            @(posedge clk); #1;
            rx_done = 1'b0;
            @(negedge clk);
            check("drop_mid", drop, 1);
            check("busy_wait_tx", busy, 1);
            @(posedge clk); #1;
         end
         tx_done = 1'b1;
         if (drop_mode == 1) begin
            rx_data = 8'h55; rx_done = 1'b1;
         end
         @(posedge clk); #1;
         tx_done = 1'b0; rx_done = 1'b0;
         @(negedge clk);
         check("busy_after_tx", busy, 0);
         check("drop_coinc", drop, (drop_mode == 1) ? 1 : 0);
         check("alu_a_kept", alu_a, a_exp);
         check("tx_data_held", tx_data, tx_exp);
         check("one_start", n_starts - starts0, 1);
      end else begin
         check("op_err", op_err, 1);
         check("busy_err", busy, 0);
         @(negedge clk);
         check("op_err_single", op_err, 0);
         check("no_start", n_starts - starts0, 0);
      end
   endtask

   task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                          input int tx_wait, input int drop_mode);
      send_byte(a);   a_exp = a;
      send_byte(b);   b_exp = b;
      send_byte(opb); op_exp = opb[5:0];
      finish_txn(tx_wait, drop_mode);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_a"}, alu_a, 0);
      check({tag, "_b"}, alu_b, 0);
      check({tag, "_op"}, alu_op, 0);
      check({tag, "_tx"}, tx_data, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_start"}, tx_start, 0);
      a_exp = '0; b_exp = '0; op_exp = '0;
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int starts0, errs0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_all_zero("reset");
      check("reset_err", op_err, 0);
      check("reset_drop", drop, 0);

      run_txn(8'h0A, 8'h05, 8'h20, 0, 0);
      run_txn(8'h0F, 8'h05, 8'h22, 2, 0);
      run_txn(8'hF0, 8'h02, 8'h03, 1, 0);
      run_txn(8'h01, 8'h02, 8'h3F, 0, 0);
      run_txn(8'h03, 8'h04, 8'h25, 0, 0);
      run_txn(8'h11, 8'h22, 8'h26, 1, 1);
      run_txn(8'h33, 8'h44, 8'hE4, 0, 2);

      // Reset while waiting for the opcode.
      send_byte(8'h77); send_byte(8'h88);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check_all_zero("rst_waitop");
      run_txn(8'h09, 8'h03, 8'h22, 0, 0);

      // Reset during COMPUTE must suppress the start pulse.
      starts0 = n_starts;
      send_byte(8'h12); send_byte(8'h34); send_byte(8'h20);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check_all_zero("rst_compute");
      repeat (4) @(negedge clk);
      check("rst_no_start", n_starts - starts0, 0);
      check("rst_idle", busy, 0);

`ifdef ALU_UART_SEQ_TIMEOUT_EN
      errs0 = n_errs;
      send_byte(8'h5A); a_exp = 8'h5A;
      repeat (16) @(posedge clk);
      @(negedge clk);
      check("timeout_err", op_err, 1);
      check("timeout_err_once", n_errs - errs0, 1);
      run_txn(8'h21, 8'h02, 8'h20, 0, 0);

      errs0 = n_errs;
      send_byte(8'h44); a_exp = 8'h44;
      repeat (14) @(posedge clk);
      send_byte(8'h66); b_exp = 8'h66;
      check("late_b", alu_b, 8'h66);
      send_byte(8'h20); op_exp = 6'b100000;
      finish_txn(0, 0);
      check("late_no_err", n_errs - errs0, 0);
`else
      errs0 = n_errs;
      send_byte(8'h5A); a_exp = 8'h5A;
      repeat (40) @(posedge clk);
      send_byte(8'h06); b_exp = 8'h06;
      send_byte(8'h24); op_exp = 6'b100100;
      finish_txn(0, 0);
      check("no_timeout", n_errs - errs0, 0);
`endif

      for (int t = 0; t < 40; t++) begin
         logic [7:0] opb;
         if ($urandom_range(0, 3) == 0) opb = 8'($urandom);
         else opb = {2'($urandom), valid_ops[$urandom_range(0, 7)]};
         if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1 tx_done = 1'b1;
            @(posedge clk); #1 tx_done = 1'b0;
         end
         run_txn(8'($urandom), 8'($urandom), opb, $urandom_range(0, 4),
                 $urandom_range(0, 2));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
